cla_addsub_pipe: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 32-bit CLA adder.

---
 rtl/cla_pkg.sv | 27 ++
 rtl/cla_add_seg.sv | 64 ++++++
 rtl/cla_addsub_pipe.sv | 139 +++++++++++++
 tb/tb_cla_addsub_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, flag struct and flag helper for the pipelined CLA adder/subtractor.
package cla_pkg;

   localparam logic OP_ADD     = 1'b0;
   localparam logic OP_SUB     = 1'b1;
   localparam int   MAX_STAGES = 8;
   localparam int   GROUP_W    = 4;

   typedef struct packed {
      logic z;
      logic v;
      logic n;
   } cla_flags_t;

   // Overflow uses the effective (possibly inverted) B operand so add and subtract share one rule.
   function automatic cla_flags_t calc_flags(input logic is_zero,
                                             input logic a_msb,
                                             input logic b_eff_msb,
                                             input logic s_msb);
      cla_flags_t f;
      f.z = is_zero;
      f.n = s_msb;
      f.v = (a_msb == b_eff_msb) && (s_msb != a_msb);
      return f;
   endfunction

endpackage

// File: rtl/cla_add_seg.sv
// Combinational SW-bit carry-lookahead segment built from 4-bit lookahead groups.
module cla_add_seg
   import cla_pkg::*;
#(
   parameter int SW = 16
)
(
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          ci,
   output logic [SW-1:0] s,
   output logic          co,
   output logic          g,
   output logic          p
);

   localparam int NG = SW / GROUP_W;

   logic [SW-1:0] bit_g;
   logic [SW-1:0] bit_p;
   logic [SW-1:0] c;
   logic [NG-1:0] grp_g;
   logic [NG-1:0] grp_p;
   logic [NG:0]   grp_c;

   assign bit_g    = a & b;
   assign bit_p    = a ^ b;
   assign grp_c[0] = ci;

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      logic [GROUP_W-1:0] gg;
      logic [GROUP_W-1:0] pp;
      logic               cin;

      assign gg  = bit_g[gi*GROUP_W +: GROUP_W];
      assign pp  = bit_p[gi*GROUP_W +: GROUP_W];
      assign cin = grp_c[gi];

      assign c[gi*GROUP_W]     = cin;
      assign c[gi*GROUP_W + 1] = gg[0] | (pp[0] & cin);
      assign c[gi*GROUP_W + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
      assign c[gi*GROUP_W + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                               | (pp[2] & pp[1] & pp[0] & cin);

      assign grp_g[gi]  = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                        | (pp[3] & pp[2] & pp[1] & gg[0]);
      assign grp_p[gi]  = &pp;
      assign grp_c[gi+1] = grp_g[gi] | (grp_p[gi] & cin);
   end

   assign s  = bit_p ^ c;
   assign co = grp_c[NG];

   // Segment-level generate/propagate folded from the group terms, LSB group first.
   always_comb begin
      g = 1'b0;
      p = 1'b1;
      for (int i = 0; i < NG; i++) begin
         g = grp_g[i] | (grp_p[i] & g);
         p = p & grp_p[i];
      end
   end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor, STAGES carry segments with valid/ready flow control.
// Optional Z/V/N flags are built only when CLA_ADDSUB_FLAGS_EN is defined.
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
)
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             z,
   output logic             v,
   output logic             n
);

   localparam int SW = WIDTH / STAGES;

   logic advance;

   // Index k is the input seen by stage k; index 0 is the port side, the rest are stage registers.
   logic [WIDTH-1:0] pipe_a [STAGES];
   logic [WIDTH-1:0] pipe_b [STAGES];
   logic [WIDTH-1:0] pipe_s [STAGES+1];
   logic             pipe_c [STAGES+1];
   logic             pipe_v [STAGES+1];

   assign advance   = !pipe_v[STAGES] || out_ready;
   assign in_ready  = advance;

   assign pipe_a[0] = a;
   assign pipe_b[0] = (op_sub == OP_SUB) ? ~b : b;
   assign pipe_s[0] = '0;
   assign pipe_c[0] = ci ^ op_sub;
   assign pipe_v[0] = in_valid;

`ifdef CLA_ADDSUB_FLAGS_EN
   cla_flags_t flags_reg;
`endif

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [SW-1:0]    seg_s;
      logic             seg_co;
      logic             seg_g;
      logic             seg_p;
      logic [WIDTH-1:0] s_next;
      logic [WIDTH-1:0] s_reg;
      logic             c_reg;
      logic             v_reg;

      cla_add_seg #(.SW(SW)) u_seg (
         .a  (pipe_a[gi][gi*SW +: SW]),
         .b  (pipe_b[gi][gi*SW +: SW]),
         .ci (pipe_c[gi]),
         .s  (seg_s),
         .co (seg_co),
         .g  (seg_g),
         .p  (seg_p)
      );

      always_comb begin
         s_next               = pipe_s[gi];
         s_next[gi*SW +: SW]  = seg_s;
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            s_reg <= '0;
            c_reg <= 1'b0;
            v_reg <= 1'b0;
         end else if (advance) begin
            s_reg <= s_next;
            c_reg <= seg_co;
            v_reg <= pipe_v[gi];
         end
      end

      assign pipe_s[gi+1] = s_reg;
      assign pipe_c[gi+1] = c_reg;
      assign pipe_v[gi+1] = v_reg;

      // Operands only travel as far as the last segment that still needs them.
      if (gi < STAGES-1) begin : g_fwd
         logic [WIDTH-1:0] a_reg;
         logic [WIDTH-1:0] b_reg;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               a_reg <= '0;
               b_reg <= '0;
            end else if (advance) begin
               a_reg <= pipe_a[gi];
               b_reg <= pipe_b[gi];
            end
         end

         assign pipe_a[gi+1] = a_reg;
         assign pipe_b[gi+1] = b_reg;
      end

`ifdef CLA_ADDSUB_FLAGS_EN
      if (gi == STAGES-1) begin : g_flags
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               flags_reg <= '0;
            end else if (advance) begin
               flags_reg <= calc_flags(s_next == '0, pipe_a[gi][WIDTH-1],
                                       pipe_b[gi][WIDTH-1], s_next[WIDTH-1]);
            end
         end
      end
`endif
   end

   assign out_valid = pipe_v[STAGES];
   assign s         = pipe_s[STAGES];
   assign co        = pipe_c[STAGES];

`ifdef CLA_ADDSUB_FLAGS_EN
   assign z = flags_reg.z;
   assign v = flags_reg.v;
   assign n = flags_reg.n;
`else
   assign z = 1'b0;
   assign v = 1'b0;
   assign n = 1'b0;
`endif

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed corner cases, latency for STAGES=1/2/8, random traffic, mid-flight reset.
module tb_cla_addsub_pipe;

   localparam int W = 32;
`ifdef CLA_ADDSUB_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         out_ready;
   logic         ci;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         aux_ready;

   logic         in_ready,  out_valid,  co,  z,  v,  n;
   logic [W-1:0] s;
   logic         in_ready1, out_valid1, co1, z1, v1, n1;
   logic [W-1:0] s1;
   logic         in_ready8, out_valid8, co8, z8, v8, n8;
   logic [W-1:0] s8;

   always #5 clock = ~clock;

   cla_addsub_pipe #(.WIDTH(W), .STAGES(2)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .z(z), .v(v), .n(n)
   );

   cla_addsub_pipe #(.WIDTH(W), .STAGES(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .ci(ci), .op_sub(op_sub), .out_valid(out_valid1), .out_ready(aux_ready),
      .s(s1), .co(co1), .z(z1), .v(v1), .n(n1)
   );

   cla_addsub_pipe #(.WIDTH(W), .STAGES(8)) dut8 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready8),
      .a(a), .b(b), .ci(ci), .op_sub(op_sub), .out_valid(out_valid8), .out_ready(aux_ready),
      .s(s8), .co(co8), .z(z8), .v(v8), .n(n8)
   );

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         z;
      logic         v;
      logic         n;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass   = 0;
   int   n_checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow.
   function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                  input logic fci, input logic fsub);
      exp_t        r;
      longint      sa, sb, sres;
      longint      ua, ub;
      ua = longint'(fa);
      ub = longint'(fb);
      sa = $signed(fa);
      sb = $signed(fb);
      if (fsub) begin
         r.s  = W'(ua - ub - longint'(fci));
         r.co = (ua >= ub + longint'(fci));
         sres = sa - sb - longint'(fci);
      end else begin
         r.s  = W'(ua + ub + longint'(fci));
         r.co = ((ua + ub + longint'(fci)) >= (64'sd1 <<< W));
         sres = sa + sb + longint'(fci);
      end
      r.z = (r.s == '0);
      r.n = r.s[W-1];
      r.v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      if (!FLAGS) begin
         r.z = 1'b0;
         r.v = 1'b0;
         r.n = 1'b0;
      end
      return r;
   endfunction

   // One op into an idle pipeline; checks the result and the latency of all three depths.
   task automatic directed(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                           input logic dci, input logic dsub, input logic [W-1:0] es,
                           input logic eco, input logic ez, input logic ev, input logic en);
      int lat2 = 0;
      int lat1 = 0;
      int lat8 = 0;
      if (!FLAGS) begin
         ez = 1'b0;
         ev = 1'b0;
         en = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) begin
         @(negedge clock);
         check({tag, "_idle"}, out_valid, 1'b0);
      end
      a = da; b = db; ci = dci; op_sub = dsub; in_valid = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clock);
         @(negedge clock);
         in_valid = 1'b0;
         if (out_valid && lat2 == 0) begin
            lat2 = e;
            check({tag, "_s"},  s,  es);
            check({tag, "_co"}, co, eco);
            check({tag, "_z"},  z,  ez);
            check({tag, "_v"},  v,  ev);
            check({tag, "_n"},  n,  en);
         end
         if (out_valid1 && lat1 == 0) begin
            lat1 = e;
            check({tag, "_s_st1"}, s1, es);
         end
         if (out_valid8 && lat8 == 0) begin
            lat8 = e;
            check({tag, "_s_st8"}, s8, es);
         end
      end
      check({tag, "_lat_st2"}, lat2, 2);
      check({tag, "_lat_st1"}, lat1, 1);
      check({tag, "_lat_st8"}, lat8, 8);
      $display("%s: a=%h b=%h ci=%0d sub=%0d -> s=%h co=%0d lat=%0d/%0d/%0d",
               tag, da, db, dci, dsub, es, eco, lat1, lat2, lat8);
   endtask

   initial begin
      exp_t         e;
      int           accepted = 0;
      int           cycles   = 0;
      logic         stalled  = 1'b0;
      logic [W-1:0] held_s   = '0;
      logic         held_co  = 1'b0;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      aux_ready = 1'b1;
      a = '0; b = '0; ci = 1'b0; op_sub = 1'b0;

      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_s",  s,  '0);
      check("rst_co", co, 1'b0);
      check("rst_flags", {z, v, n}, 3'b000);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      directed("add_1_1",      32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
      directed("add_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
      directed("add_seg_cross",32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      directed("sub_5_7",      32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
      directed("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
      directed("add_min_min",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
      directed("sub_borrow_in",32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);

      // Random traffic with a randomly stalling consumer.
      while ((accepted < 100 || exp_q.size() > 0) && cycles < 3000) begin
         @(negedge clock);
         cycles++;
         if (stalled) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_s",  s,  held_s);
            check("hold_co", co, held_co);
         end
         in_valid  = (accepted < 100) && ($urandom_range(0, 3) != 0);
         a         = $urandom;
         b         = $urandom;
         ci        = 1'($urandom_range(0, 1));
         op_sub    = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         #1;
         check("in_ready_eq_advance", in_ready, !out_valid || out_ready);
         if (out_valid && out_ready) begin
            check("out_has_expect", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rnd_s",  s,  e.s);
               check("rnd_co", co, e.co);
               check("rnd_zvn", {z, v, n}, {e.z, e.v, e.n});
               $display("rnd out: s=%h co=%0d zvn=%b%b%b", s, co, z, v, n);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, ci, op_sub));
            accepted++;
         end
         stalled = out_valid && !out_ready;
         held_s  = s;
         held_co = co;
      end
      check("rnd_complete", (accepted == 100) && (exp_q.size() == 0), 1'b1);

      // Two ops in flight, then an asynchronous reset pulse.
      @(negedge clock);
      out_ready = 1'b1;
      in_valid  = 1'b1; a = 32'h0000_1111; b = 32'h0000_2222; ci = 1'b0; op_sub = 1'b0;
      @(negedge clock);
      a = 32'h0000_3333; b = 32'h0000_4444;
      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("pre_rst_valid", out_valid, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_s",  s,  '0);
      check("mid_rst_co", co, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      exp_q.delete();
      $display("reset pulse with 2 ops in flight");

      directed("post_reset", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
